// File: rtl/deck_shuffler.sv
// Fisher-Yates deck shuffler: builds an identity deck, shuffles it with rejection
// sampling on a free-running random source, then deals cards one per request.
module deck_shuffler #(
    parameter int N_CARDS = 52,
    parameter int W       = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] rnd_in,
    output logic         busy,
    output logic         done,
    input  logic         deal_req,
    output logic         card_valid,
    output logic [W-1:0] card_out,
    output logic [W-1:0] cards_left,
    output logic         deck_empty
);

    typedef enum logic [1:0] {IDLE, INIT, DRAW, READY} state_t;

    localparam logic [W-1:0] LAST = W'(N_CARDS - 1);
    localparam logic [W-1:0] FULL = W'(N_CARDS);
    localparam logic [W-1:0] ONE  = W'(1);

    state_t       state, state_next;
    logic [W-1:0] deck [0:N_CARDS-1];
    logic [W-1:0] k, i, p;
    logic [W-1:0] mask, j;
    logic         accept;

    // Smallest all-ones value covering v: smear every set bit downwards.
    function automatic logic [W-1:0] mask_of(input logic [W-1:0] v);
        logic [W-1:0] m;
        m = v;
        for (int s = 1; s < W; s++) begin
            m = m | (v >> s);
        end
        return m;
    endfunction

    assign mask   = mask_of(i);
    assign j      = rnd_in & mask;
    assign accept = (j <= i);

    assign busy       = (state == INIT) || (state == DRAW);
    assign deck_empty = (state == READY) && (cards_left == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = INIT;
            INIT:    if (k == LAST) state_next = DRAW;
            DRAW:    if (accept && (i == ONE)) state_next = READY;
            READY:   if (start) state_next = INIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            i          <= '0;
            p          <= '0;
            cards_left <= '0;
            done       <= 1'b0;
            card_valid <= 1'b0;
            card_out   <= '0;
        end else begin
            state      <= state_next;
            done       <= 1'b0;
            card_valid <= 1'b0;
            case (state)
                IDLE: k <= '0;
                INIT: begin
                    if (k != LAST) k <= k + 1'b1;
                    else           i <= LAST;
                end
                DRAW: begin
                    if (accept) begin
                        if (i == ONE) begin
                            done       <= 1'b1;
                            cards_left <= FULL;
                            p          <= '0;
                        end else begin
                            i <= i - 1'b1;
                        end
                    end
                end
                READY: begin
                    // A reshuffle request wins over a deal in the same cycle.
                    if (start) begin
                        k          <= '0;
                        cards_left <= '0;
                    end else if (deal_req && (cards_left != '0)) begin
                        card_valid <= 1'b1;
                        card_out   <= deck[p];
                        p          <= p + 1'b1;
                        cards_left <= cards_left - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Deck contents need no reset; INIT rebuilds them before every shuffle.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            deck[k] <= k;
        end else if ((state == DRAW) && accept) begin
            deck[i] <= deck[j];
            deck[j] <= deck[i];
        end
    end

endmodule
